// File: rtl/branch_target_predictor.sv
// Direct-mapped tagged branch target predictor with saturating counters and debug statistics.
// Lookup is combinational (zero latency); updates become visible the cycle after upd_valid.
// No backpressure: one lookup and one update are accepted every cycle.
module branch_target_predictor #(
   parameter int IDX_W  = 6,
   parameter int TAG_W  = 8,
   parameter int CNT_W  = 2,
   parameter int STAT_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       lk_pc,
   output logic              pred_taken,
   output logic [31:0]       pred_target,
   input  logic              upd_valid,
   input  logic [31:0]       upd_pc,
   input  logic              upd_taken,
   input  logic [31:0]       upd_target,
   input  logic              upd_pred,
   input  logic              flush,
   output logic [STAT_W-1:0] stat_branches,
   output logic [STAT_W-1:0] stat_mispred
);

   localparam int DEPTH = 1 << IDX_W;

   // Counter encodings: weakly taken on allocation, weakly not-taken out of reset.
   localparam logic [CNT_W-1:0] CNT_WT  = {1'b1, {(CNT_W-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_WNT = {1'b0, {(CNT_W-1){1'b1}}};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_MIN = {CNT_W{1'b0}};

   // Table storage; targets are word aligned so bits [1:0] are not kept.
   logic [DEPTH-1:0] valid_q;
   logic [TAG_W-1:0] tag_q [DEPTH];
   logic [CNT_W-1:0] cnt_q [DEPTH];
   logic [29:0]      tgt_q [DEPTH];

   logic [IDX_W-1:0] lk_idx;
   logic [TAG_W-1:0] lk_tag;
   logic             lk_hit;

   logic [IDX_W-1:0] up_idx;
   logic [TAG_W-1:0] up_tag;
   logic             up_hit;
   logic             up_accept;
   logic             up_wr;
   logic [CNT_W-1:0] up_cnt_nxt;
   logic [29:0]      up_tgt_nxt;

   assign lk_idx = lk_pc[IDX_W+1:2];
   assign lk_tag = lk_pc[IDX_W+TAG_W+1:IDX_W+2];
   assign up_idx = upd_pc[IDX_W+1:2];
   assign up_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

   // Lookup: reads the registered table only, so a same-cycle update is not bypassed.
   always_comb begin
      lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      pred_taken  = lk_hit && cnt_q[lk_idx][CNT_W-1] && !lk_pc[31];
      pred_target = 32'b0;
      if (pred_taken) begin
         pred_target = {tgt_q[lk_idx], 2'b00};
      end
   end

   // Update decode: flush discards the update; kernel PCs and not-taken misses never write.
   always_comb begin
      up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
      up_accept  = upd_valid && !flush;
      up_wr      = up_accept && !upd_pc[31] && (up_hit || upd_taken);
      up_cnt_nxt = cnt_q[up_idx];
      up_tgt_nxt = tgt_q[up_idx];
      if (!up_hit) begin
         up_cnt_nxt = CNT_WT;
         up_tgt_nxt = upd_target[31:2];
      end else if (upd_taken) begin
         up_tgt_nxt = upd_target[31:2];
         if (cnt_q[up_idx] != CNT_MAX) begin
            up_cnt_nxt = cnt_q[up_idx] + 1'b1;
         end
      end else begin
         if (cnt_q[up_idx] != CNT_MIN) begin
            up_cnt_nxt = cnt_q[up_idx] - 1'b1;
         end
      end
   end

   // Table state: flush only drops valid bits, leaving tag/counter/target contents intact.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            tag_q[i] <= '0;
            cnt_q[i] <= CNT_WNT;
            tgt_q[i] <= '0;
         end
      end else if (flush) begin
         valid_q <= '0;
      end else if (up_wr) begin
         valid_q[up_idx] <= 1'b1;
         tag_q[up_idx]   <= up_tag;
         cnt_q[up_idx]   <= up_cnt_nxt;
         tgt_q[up_idx]   <= up_tgt_nxt;
      end
   end

   // Statistics: count every accepted update, including kernel-mode branches; wrap naturally.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_branches <= '0;
         stat_mispred  <= '0;
      end else if (up_accept) begin
         stat_branches <= stat_branches + 1'b1;
         if (upd_pred != upd_taken) begin
            stat_mispred <= stat_mispred + 1'b1;
         end
      end
   end

endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Parametrised branch prediction unit for the five-stage pipeline; replaces the fixed not-taken fetch policy.
- IF stage looks up the current PC each cycle and gets a combinational taken/target prediction.
- ID stage, where branches resolve, writes back the actual outcome.
- Holds a direct-mapped table of tagged entries (saturating counter + target) and two performance counters for the debug path.

Parameters:
- IDX_W, 6, index width; table has 2**IDX_W entries.
- TAG_W, 8, tag width stored per entry.
- CNT_W, 2, saturating counter width (minimum 2).
- STAT_W, 32, width of each performance counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset; sequential logic is sensitive to negedge reset or posedge clk.
- lk_pc  input  32  IF-stage PC to predict (bit 31 = supervisor bit).
- pred_taken  output  1  predict taken for lk_pc.
- pred_target  output  32  predicted next PC; valid when pred_taken=1, else 0.
- upd_valid  input  1  ID stage resolved a conditional branch this cycle.
- upd_pc  input  32  PC of the resolved branch.
- upd_taken  input  1  actual outcome.
- upd_target  input  32  actual branch target (ConBA).
- upd_pred  input  1  prediction that was made for this branch in IF.
- flush  input  1  invalidate entire table (e.g. after ROM reload).
- stat_branches  output  STAT_W  count of accepted updates.
- stat_mispred  output  STAT_W  count of accepted updates with upd_pred != upd_taken.

Behaviour:
Addressing
- idx = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- Entry = {valid, tag, cnt[CNT_W-1:0], target[31:2]}.
- Stored target drops bits [1:0]; output target is {target, 2'b00}.

Lookup (combinational from registered table, zero latency)
- hit = valid[idx] && tag match.
- pred_taken = hit && cnt MSB==1 && lk_pc[31]==0.
- Kernel-mode PCs are never predicted taken.
- pred_target = pred_taken ? stored target : 32'b0.

Update (registered; visible to lookup the cycle after upd_valid)
- Hit, taken: cnt saturating +1 (max all-ones); target <= upd_target[31:2].
- Hit, not taken: cnt saturating -1 (min 0); target unchanged.
- Miss, taken: allocate/replace entry:
  - valid=1, tag written, target written;
  - cnt = weakly taken (MSB=1, other bits 0; 2'b10 for CNT_W=2).
- Miss, not taken: no table write.
- upd_pc[31]==1: no table write; statistics still count it.

Statistics
- On every upd_valid with flush=0: stat_branches += 1.
- Same condition plus upd_pred != upd_taken: stat_mispred += 1.
- Both wrap modulo 2**STAT_W.
- Not cleared by flush.

Simultaneous events
- Lookup and update on the same idx in the same cycle: lookup sees pre-update contents; no bypass.
- flush and upd_valid in the same cycle: flush wins.
  - All valid bits cleared; update and statistics both discarded.
- flush does not modify cnt/target/tag storage, only valid bits.

Reset (asynchronous, reset=0)
- All valid=0.
- All cnt = weakly not-taken (MSB=0, others 1; 2'b01).
- Tags/targets = 0; stat_branches = stat_mispred = 0.
- Hence pred_taken=0 and pred_target=0 immediately, independent of clk.
- Reset asserted mid-update: update lost. After release, the first posedge behaves as a fresh table.

Test Plan:
1. Reset, lk_pc=0x00000040 -> pred_taken=0, pred_target=0, stats 0.
2. Update pc=0x00000040 taken target=0x00000100 (upd_pred=0); next cycle lk_pc=0x00000040 -> pred_taken=1, pred_target=0x00000100; stat_branches=1, stat_mispred=1.
3. Two not-taken updates on pc=0x40 after scenario 2 -> cnt 10->01->00, pred_taken=0. Three taken updates -> cnt 01,10,11 (saturates), pred_taken=1.
4. Alias: pc=0x40 then pc=0x00000140 (same idx, different tag) taken target 0x200 -> lk 0x40 misses (pred 0), lk 0x140 predicts 0x200.
5. Same-cycle lookup+update on 0x40 (first taken) -> pred_taken=0 that cycle, 1 next cycle. Same-cycle flush+update -> table empty, stat_branches unchanged.
6. Update pc=0x80000040 taken -> no allocation, lk_pc=0x80000040 pred_taken=0, stat_branches increments. Assert reset mid-sequence -> all outputs 0 asynchronously.
